operand_fetch: RTL and testbench

- Register-read stage between decode and execute.
- Drives the two read addresses of the general-purpose register file and collects the two operands.
- Overrides the file data with in-flight results: EX, then MEM, then write-back, in that priority order.
- Interlocks load-use hazards and presents registered operands to EX over a valid/ready handshake.
- Holds the only per-stage state for hazard tracking and keeps a saturating stall counter for performance reporting.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fwd_mux.sv | 39 +++
 rtl/operand_fetch.sv | 190 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared widths and operand-fetch state encoding           |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } of_state_e;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fwd_mux : resolves one source operand from EX/MEM/WB or file data  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fwd_mux #(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic [AW-1:0] src,
  input  logic          ex_en,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_data,
  input  logic          mem_en,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic [DW-1:0] file_data,
  output logic [DW-1:0] val
);

  // Youngest producer wins; WB covers the file's read-old-during-write behaviour.
  always_comb begin
    val = file_data;
    if (src == '0) begin
      val = '0;
    end else if (ex_en && (ex_rd == src)) begin
      val = ex_data;
    end else if (mem_en && (mem_rd == src)) begin
      val = mem_data;
    end else if (wb_en && (wb_rd == src)) begin
      val = wb_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_fetch : register-read stage with forwarding and load-use   |
// | interlock, registered valid/ready output toward EX                 |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module operand_fetch
  import cpu_pkg::of_state_e, cpu_pkg::RUN, cpu_pkg::LU_STALL;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic          in_wen,
  input  logic          in_is_load,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] rb,
  input  logic [DW-1:0] busa,
  input  logic [DW-1:0] busb,
  input  logic          ex_fwd_en,
  input  logic [AW-1:0] ex_fwd_rd,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          mem_fwd_en,
  input  logic [AW-1:0] mem_fwd_rd,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          ex_adv,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_opa,
  output logic [DW-1:0] out_opb,
  output logic [AW-1:0] out_rd,
  output logic          out_wen,
  output logic          out_is_load,
  output logic [CW-1:0] stall_cnt
);

  of_state_e     state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          wen_q, wen_d;
  logic          is_load_q, is_load_d;
  logic          ld_pend_q, ld_pend_d;
  logic [AW-1:0] ld_rd_q, ld_rd_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic          hazard;
  logic          xfer;
  logic          accept;
  logic          ld_set;
  logic [DW-1:0] opa_res;
  logic [DW-1:0] opb_res;

  assign ra = in_rs;
  assign rb = in_rt;

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .src       (in_rs),
    .ex_en     (ex_fwd_en),
    .ex_rd     (ex_fwd_rd),
    .ex_data   (ex_fwd_data),
    .mem_en    (mem_fwd_en),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .file_data (busa),
    .val       (opa_res)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .src       (in_rt),
    .ex_en     (ex_fwd_en),
    .ex_rd     (ex_fwd_rd),
    .ex_data   (ex_fwd_data),
    .mem_en    (mem_fwd_en),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .file_data (busb),
    .val       (opb_res)
  );

  assign hazard = ld_pend_q && ((ld_rd_q == in_rs) || (ld_rd_q == in_rt));
  assign xfer   = out_valid_q && out_ready;
  assign accept = in_valid && in_ready && !flush;
  assign ld_set = xfer && is_load_q && wen_q && (rd_q != '0);

  always_comb begin
    in_ready = 1'b0;
    if (state_q == RUN) begin
      in_ready = !hazard && (!out_valid_q || out_ready);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    is_load_d   = is_load_q;
    ld_pend_d   = ld_pend_q;
    ld_rd_d     = ld_rd_q;
    stall_cnt_d = stall_cnt_q;
    state_d     = RUN;

    if (flush) begin
      out_valid_d = 1'b0;
      ld_pend_d   = 1'b0;
    end else begin
      if (accept) begin
        out_valid_d = 1'b1;
        opa_d       = opa_res;
        opb_d       = opb_res;
        rd_d        = in_rd;
        wen_d       = in_wen;
        is_load_d   = in_is_load;
      end else if (xfer) begin
        out_valid_d = 1'b0;
      end
      // A load entering EX outranks the retirement of the previous one.
      if (ld_set) begin
        ld_pend_d = 1'b1;
        ld_rd_d   = rd_q;
      end else if (ex_adv) begin
        ld_pend_d = 1'b0;
      end
      // Stay stalled only while the load will still be pending next cycle.
      if (((state_q == LU_STALL) || (in_valid && hazard)) && ld_pend_d) begin
        state_d = LU_STALL;
      end
    end

    if (in_valid && hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      is_load_q   <= 1'b0;
      ld_pend_q   <= 1'b0;
      ld_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      is_load_q   <= is_load_d;
      ld_pend_q   <= ld_pend_d;
      ld_rd_q     <= ld_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opa     = opa_q;
  assign out_opb     = opb_q;
  assign out_rd      = rd_q;
  assign out_wen     = wen_q;
  assign out_is_load = is_load_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_operand_fetch : directed and randomized checks of operand_fetch |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic          in_wen, in_is_load;
  logic [AW-1:0] ra, rb;
  logic [DW-1:0] busa, busb;
  logic          ex_fwd_en;
  logic [AW-1:0] ex_fwd_rd;
  logic [DW-1:0] ex_fwd_data;
  logic          mem_fwd_en;
  logic [AW-1:0] mem_fwd_rd;
  logic [DW-1:0] mem_fwd_data;
  logic          wb_en;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          ex_adv, flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_opa, out_opb;
  logic [AW-1:0] out_rd;
  logic          out_wen, out_is_load;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;

  operand_fetch #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_wen(in_wen), .in_is_load(in_is_load),
    .ra(ra), .rb(rb), .busa(busa), .busb(busb),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_adv(ex_adv), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opa(out_opa), .out_opb(out_opb), .out_rd(out_rd),
    .out_wen(out_wen), .out_is_load(out_is_load),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_fwd;
    ex_fwd_en  = 1'b0;
    mem_fwd_en = 1'b0;
    wb_en      = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic wen, input logic ld);
    in_valid   = 1'b1;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_wen     = wen;
    in_is_load = ld;
  endtask

  task automatic add_stall(input int n);
    exp_stall = exp_stall + n;
    if (exp_stall > SAT) exp_stall = SAT;
  endtask

  // Reference: producers listed youngest first; the first matching one supplies the value.
  function automatic logic [DW-1:0] ref_op(input logic [AW-1:0] s, input logic [DW-1:0] file);
    logic          en  [3];
    logic [AW-1:0] rd  [3];
    logic [DW-1:0] dat [3];
    en  = '{ex_fwd_en, mem_fwd_en, wb_en};
    rd  = '{ex_fwd_rd, mem_fwd_rd, wb_rd};
    dat = '{ex_fwd_data, mem_fwd_data, wb_data};
    if (s == '0) return '0;
    for (int i = 0; i < 3; i++) begin
      if (en[i] && (rd[i] == s)) return dat[i];
    end
    return file;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp_a, exp_b, d;
    logic [AW-1:0] exp_rd, r;
    logic          exp_wen;
    int            k;

    rst = 1'b1;
    in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
    busa = '0; busb = '0;
    ex_fwd_rd = '0; ex_fwd_data = '0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_rd = '0; wb_data = '0;
    idle_fwd();
    ex_adv = 1'b1; flush = 1'b0; out_ready = 1'b1;

    // Reset
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_ld_pend", dut.ld_pend_q, 0);
    check("rst_out_opa", out_opa, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Priority EX > MEM > WB > file
    issue(5'd3, 5'd0, 5'd9, 1'b1, 1'b0);
    busa = 32'h44; busb = 32'h55;
    ex_fwd_en = 1'b1;  ex_fwd_rd = 5'd3;  ex_fwd_data = 32'h11;
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h22;
    wb_en = 1'b1;      wb_rd = 5'd3;      wb_data = 32'h33;
    settle();
    check("ra_copy", ra, 3);
    tick();
    check("prio_valid", out_valid, 1);
    check("prio_ex", out_opa, 32'h11);
    check("prio_rt0", out_opb, 0);
    check("prio_rd", out_rd, 9);
    ex_fwd_en = 1'b0;
    tick();
    check("prio_mem", out_opa, 32'h22);
    mem_fwd_en = 1'b0;
    tick();
    check("prio_wb", out_opa, 32'h33);
    wb_en = 1'b0;
    tick();
    check("prio_file", out_opa, 32'h44);

    // Register 0 always reads zero
    issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    busa = 32'hDEADBEEF; busb = 32'hDEADBEEF;
    ex_fwd_en = 1'b1;  ex_fwd_rd = 5'd0;  ex_fwd_data = 32'h99;
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h98;
    tick();
    check("r0_opa", out_opa, 0);
    check("r0_opb", out_opb, 0);
    idle_fwd();

    // Load-use: lw r5 then add r6 <- r5 + r1
    issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    busa = 32'h1000;
    tick();
    check("lw_captured", out_is_load, 1);
    in_valid = 1'b0;
    tick();
    check("lw_pend_set", dut.ld_pend_q, 1);
    check("lw_out_empty", out_valid, 0);
    issue(5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    busa = 32'h0; busb = 32'h7;
    settle();
    check("lu_in_ready_stall", in_ready, 0);
    tick();
    add_stall(1);
    check("lu_stall_cnt", stall_cnt, exp_stall);
    check("lu_pend_clr", dut.ld_pend_q, 0);
    check("lu_no_capture", out_valid, 0);
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h1234;
    settle();
    check("lu_in_ready_go", in_ready, 1);
    tick();
    check("lu_opa_mem", out_opa, 32'h1234);
    check("lu_opb_file", out_opb, 32'h7);
    check("lu_rd", out_rd, 6);
    check("lu_valid", out_valid, 1);
    in_valid = 1'b0;
    idle_fwd();
    tick();

    // Flush during a load-use stall
    issue(5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    issue(5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    busa = 32'h77;
    ex_adv = 1'b0;
    settle();
    check("fl_stalled", in_ready, 0);
    tick();
    add_stall(1);
    check("fl_cnt_before", stall_cnt, exp_stall);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_ld_pend", dut.ld_pend_q, 0);
    check("fl_cnt_kept", stall_cnt, exp_stall);
    issue(5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    settle();
    check("fl_in_ready", in_ready, 1);
    tick();
    check("fl_dep_valid", out_valid, 1);
    check("fl_dep_opa", out_opa, 32'h77);
    check("fl_cnt_after", stall_cnt, exp_stall);
    ex_adv = 1'b1;
    in_valid = 1'b0;
    tick();

    // Backpressure holds the output register
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
    busa = 32'h100; busb = 32'h101;
    tick();
    check("bp_valid", out_valid, 1);
    issue(5'd3, 5'd4, 5'd11, 1'b0, 1'b0);
    busa = 32'h200; busb = 32'h201;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_hold_opa", out_opa, 32'h100);
      check("bp_hold_opb", out_opb, 32'h101);
      check("bp_hold_rd", out_rd, 10);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release", in_ready, 1);
    tick();
    check("bp_next_opa", out_opa, 32'h200);
    check("bp_next_opb", out_opb, 32'h201);
    check("bp_next_rd", out_rd, 11);
    check("bp_next_wen", out_wen, 0);
    in_valid = 1'b0;
    tick();

    // Load-use stalls of random length; the last one drives the counter into saturation
    for (int j = 0; j < 4; j++) begin
      k = (j == 3) ? 10 : int'($urandom_range(1, 4));
      r = AW'(12 + j);
      issue(5'd1, 5'd0, r, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      issue(5'd0, r, 5'd13, 1'b1, 1'b0);
      ex_adv = 1'b0;
      for (int i = 0; i < k; i++) begin
        settle();
        check("rs_hold_stall", in_ready, 0);
        tick();
      end
      ex_adv = 1'b1;
      settle();
      check("rs_last_stall", in_ready, 0);
      tick();
      add_stall(k + 1);
      settle();
      check("rs_in_ready", in_ready, 1);
      check("rs_stall_cnt", stall_cnt, exp_stall);
      d = $urandom;
      mem_fwd_en = 1'b1; mem_fwd_rd = r; mem_fwd_data = d;
      tick();
      check("rs_opb_mem", out_opb, d);
      in_valid = 1'b0;
      idle_fwd();
      tick();
    end
    check("sat_stall_cnt", stall_cnt, SAT);

    // Randomized operand resolution
    for (int j = 0; j < 30; j++) begin
      issue(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
      busa = $urandom; busb = $urandom;
      ex_fwd_en  = 1'($urandom_range(0, 1)); ex_fwd_rd  = AW'($urandom_range(0, 3)); ex_fwd_data  = $urandom;
      mem_fwd_en = 1'($urandom_range(0, 1)); mem_fwd_rd = AW'($urandom_range(0, 3)); mem_fwd_data = $urandom;
      wb_en      = 1'($urandom_range(0, 1)); wb_rd      = AW'($urandom_range(0, 3)); wb_data      = $urandom;
      settle();
      exp_a   = ref_op(in_rs, busa);
      exp_b   = ref_op(in_rt, busb);
      exp_rd  = in_rd;
      exp_wen = in_wen;
      tick();
      check("rnd_opa", out_opa, exp_a);
      check("rnd_opb", out_opb, exp_b);
      check("rnd_rd", out_rd, exp_rd);
      check("rnd_wen", out_wen, exp_wen);
    end
    in_valid = 1'b0;
    idle_fwd();
    tick();
    check("end_stall_cnt", stall_cnt, SAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
